// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that bridges host register accesses onto the single-cycle
// SRAM-style register port of the DMA controller.
module axil_reg_bridge #(
   parameter int ADDR_WIDTH      = 32,
   parameter int AXI_DATA_WIDTH  = 32,
   parameter int AXIL_ADDR_WIDTH = 32,
   parameter int NUM_REGS        = 16
) (
   input  logic                          clk,
   input  logic                          rstn,

   input  logic [AXIL_ADDR_WIDTH-1:0]    s_axil_awaddr,
   input  logic                          s_axil_awvalid,
   output logic                          s_axil_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
   input  logic                          s_axil_wvalid,
   output logic                          s_axil_wready,
   output logic [1:0]                    s_axil_bresp,
   output logic                          s_axil_bvalid,
   input  logic                          s_axil_bready,

   input  logic [AXIL_ADDR_WIDTH-1:0]    s_axil_araddr,
   input  logic                          s_axil_arvalid,
   output logic                          s_axil_arready,
   output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
   output logic [1:0]                    s_axil_rresp,
   output logic                          s_axil_rvalid,
   input  logic                          s_axil_rready,

   output logic                          reg_wr_en,
   output logic [ADDR_WIDTH-1:0]         reg_wr_addr,
   output logic [AXI_DATA_WIDTH-1:0]     reg_wr_data,
   output logic                          reg_rd_en,
   output logic [ADDR_WIDTH-1:0]         reg_rd_addr,
   input  logic [AXI_DATA_WIDTH-1:0]     reg_rd_data
);

   localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
   localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
   localparam int WIDE_WIDTH = (ADDR_WIDTH > AXIL_ADDR_WIDTH) ? ADDR_WIDTH : AXIL_ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Every channel handshake completes on a rising clk edge where valid and
   // ready are both 1; a source keeps valid and payload stable until then.

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_COMMIT = 2'd1,
      WR_RESP   = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_FETCH = 2'd1,
      RD_RESP  = 2'd2
   } rd_state_t;

   // Zero-extend first so truncation to ADDR_WIDTH works for any width pairing.
   function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [AXIL_ADDR_WIDTH-1:0] byte_addr);
      logic [WIDE_WIDTH-1:0] ext;
      ext = WIDE_WIDTH'(byte_addr) >> BYTE_SHIFT;
      return ADDR_WIDTH'(ext);
   endfunction

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
      return {1'b0, idx} < NUM_REGS_W;
   endfunction

   // ---------------------------------------------------------------- write
   wr_state_t                     wr_state_q, wr_state_d;
   logic                          aw_held_q, aw_held_d;
   logic                          w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0]         aw_idx_q, aw_idx_d;
   logic [AXI_DATA_WIDTH-1:0]     w_data_q, w_data_d;
   logic [STRB_WIDTH-1:0]         w_strb_q, w_strb_d;
   logic                          awready_q, awready_d;
   logic                          wready_q, wready_d;
   logic                          bvalid_q, bvalid_d;
   logic [1:0]                    bresp_q, bresp_d;
   logic                          wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
   logic [AXI_DATA_WIDTH-1:0]     wr_data_q, wr_data_d;

   logic                          aw_hs, w_hs;
   logic [ADDR_WIDTH-1:0]         aw_idx_cur;
   logic [AXI_DATA_WIDTH-1:0]     w_data_cur;
   logic [STRB_WIDTH-1:0]         w_strb_cur;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_state_q <= WR_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_idx_q   <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_idx_q   <= aw_idx_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_idx_d   = aw_idx_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      aw_hs      = s_axil_awvalid && awready_q;
      w_hs       = s_axil_wvalid && wready_q;
      // A beat arriving this cycle is used directly so the commit is not delayed.
      aw_idx_cur = aw_held_q ? aw_idx_q : word_index(s_axil_awaddr);
      w_data_cur = w_held_q ? w_data_q : s_axil_wdata;
      w_strb_cur = w_held_q ? w_strb_q : s_axil_wstrb;

      case (wr_state_q)
         WR_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               aw_idx_d  = word_index(s_axil_awaddr);
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               w_data_d = s_axil_wdata;
               w_strb_d = s_axil_wstrb;
            end
            if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
               wr_state_d = WR_COMMIT;
               awready_d  = 1'b0;
               wready_d   = 1'b0;
               if (in_range(aw_idx_cur) && (&w_strb_cur)) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = aw_idx_cur;
                  wr_data_d = w_data_cur;
                  bresp_d   = RESP_OKAY;
               end else begin
                  bresp_d   = RESP_SLVERR;
               end
            end else begin
               awready_d = !aw_held_d;
               wready_d  = !w_held_d;
            end
         end
         WR_COMMIT: begin
            wr_state_d = WR_RESP;
         end
         WR_RESP: begin
            if (bvalid_q && s_axil_bready) begin
               bvalid_d   = 1'b0;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
               wr_state_d = WR_IDLE;
            end else begin
               bvalid_d = 1'b1;
            end
         end
         default: begin
            wr_state_d = WR_IDLE;
         end
      endcase
   end

   // ----------------------------------------------------------------- read
   rd_state_t                     rd_state_q, rd_state_d;
   logic                          arready_q, arready_d;
   logic                          rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0]         rd_addr_q, rd_addr_d;
   logic                          rvalid_q, rvalid_d;
   logic [AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [1:0]                    rresp_q, rresp_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_state_q <= RD_IDLE;
         arready_q  <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = arready_q;
      rd_en_d    = rd_en_q;
      rd_addr_d  = rd_addr_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;

      case (rd_state_q)
         RD_IDLE: begin
            if (s_axil_arvalid && arready_q) begin
               rd_addr_d  = word_index(s_axil_araddr);
               rd_en_d    = 1'b1;
               arready_d  = 1'b0;
               rd_state_d = RD_FETCH;
            end else begin
               arready_d  = 1'b1;
            end
         end
         RD_FETCH: begin
            // Controller data is combinational on reg_rd_addr; capture it now.
            rd_en_d    = 1'b0;
            rvalid_d   = 1'b1;
            rd_state_d = RD_RESP;
            if (in_range(rd_addr_q)) begin
               rdata_d = reg_rd_data;
               rresp_d = RESP_OKAY;
            end else begin
               rdata_d = '0;
               rresp_d = RESP_SLVERR;
            end
         end
         RD_RESP: begin
            if (rvalid_q && s_axil_rready) begin
               rvalid_d   = 1'b0;
               arready_d  = 1'b1;
               rd_state_d = RD_IDLE;
            end
         end
         default: begin
            rd_state_d = RD_IDLE;
         end
      endcase
   end

   assign s_axil_awready = awready_q;
   assign s_axil_wready  = wready_q;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_bresp   = bresp_q;
   assign s_axil_arready = arready_q;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = rresp_q;
   assign reg_wr_en      = wr_en_q;
   assign reg_wr_addr    = wr_addr_q;
   assign reg_wr_data    = wr_data_q;
   assign reg_rd_en      = rd_en_q;
   assign reg_rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed bench for axil_reg_bridge: a 16-entry register model stands in for
// the DMA controller and each task checks one scenario inline.
module tb_axil_reg_bridge;

   logic        clk;
   logic        rstn;
   logic [31:0] s_axil_awaddr;
   logic        s_axil_awvalid;
   logic        s_axil_awready;
   logic [31:0] s_axil_wdata;
   logic [3:0]  s_axil_wstrb;
   logic        s_axil_wvalid;
   logic        s_axil_wready;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_bvalid;
   logic        s_axil_bready;
   logic [31:0] s_axil_araddr;
   logic        s_axil_arvalid;
   logic        s_axil_arready;
   logic [31:0] s_axil_rdata;
   logic [1:0]  s_axil_rresp;
   logic        s_axil_rvalid;
   logic        s_axil_rready;
   logic        reg_wr_en;
   logic [31:0] reg_wr_addr;
   logic [31:0] reg_wr_data;
   logic        reg_rd_en;
   logic [31:0] reg_rd_addr;
   logic [31:0] reg_rd_data;

   int total;
   int bad;

   axil_reg_bridge dut (
      .clk            (clk),
      .rstn           (rstn),
      .s_axil_awaddr  (s_axil_awaddr),
      .s_axil_awvalid (s_axil_awvalid),
      .s_axil_awready (s_axil_awready),
      .s_axil_wdata   (s_axil_wdata),
      .s_axil_wstrb   (s_axil_wstrb),
      .s_axil_wvalid  (s_axil_wvalid),
      .s_axil_wready  (s_axil_wready),
      .s_axil_bresp   (s_axil_bresp),
      .s_axil_bvalid  (s_axil_bvalid),
      .s_axil_bready  (s_axil_bready),
      .s_axil_araddr  (s_axil_araddr),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rdata   (s_axil_rdata),
      .s_axil_rresp   (s_axil_rresp),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready),
      .reg_wr_en      (reg_wr_en),
      .reg_wr_addr    (reg_wr_addr),
      .reg_wr_data    (reg_wr_data),
      .reg_rd_en      (reg_rd_en),
      .reg_rd_addr    (reg_rd_addr),
      .reg_rd_data    (reg_rd_data)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // register model: reset value of entry i is i, updated on the write-enable edge
   logic [31:0] mem [16];
   int wr_pulses = 0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'(i);
      end else if (reg_wr_en && reg_wr_addr < 32'd16) begin
         mem[reg_wr_addr[3:0]] <= reg_wr_data;
      end
   end

   always @(posedge clk) begin
      if (reg_wr_en) wr_pulses <= wr_pulses + 1;
   end

   assign reg_rd_data = (reg_rd_addr < 32'd16) ? mem[reg_rd_addr[3:0]] : 32'hDEAD_BEEF;

   // driver tasks: entered and left 1 time unit after a rising edge
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output bit to);
      int n;
      bit aw_acc, w_acc;
      to = 1'b0;
      resp = 2'bxx;
      s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
      n = 0;
      while ((s_axil_awvalid || s_axil_wvalid) && n < 20) begin
         aw_acc = s_axil_awvalid && s_axil_awready;
         w_acc  = s_axil_wvalid && s_axil_wready;
         @(posedge clk); #1;
         if (aw_acc) s_axil_awvalid = 1'b0;
         if (w_acc)  s_axil_wvalid  = 1'b0;
         n++;
      end
      if (s_axil_awvalid || s_axil_wvalid) begin
         to = 1'b1; s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
         return;
      end
      s_axil_bready = 1'b1;
      n = 0;
      while (!s_axil_bvalid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!s_axil_bvalid) to = 1'b1;
      else resp = s_axil_bresp;
      @(posedge clk); #1;
      s_axil_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output bit to);
      int n;
      bit acc;
      to = 1'b0;
      data = 'x;
      resp = 2'bxx;
      s_axil_araddr = addr; s_axil_arvalid = 1'b1;
      n = 0;
      while (s_axil_arvalid && n < 20) begin
         acc = s_axil_arready;
         @(posedge clk); #1;
         if (acc) s_axil_arvalid = 1'b0;
         n++;
      end
      if (s_axil_arvalid) begin
         to = 1'b1; s_axil_arvalid = 1'b0;
         return;
      end
      s_axil_rready = 1'b1;
      n = 0;
      while (!s_axil_rvalid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!s_axil_rvalid) to = 1'b1;
      else begin
         data = s_axil_rdata; resp = s_axil_rresp;
      end
      @(posedge clk); #1;
      s_axil_rready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin bad++; $display("FAIL rst_readies got=%b exp=000", {s_axil_awready, s_axil_wready, s_axil_arready}); end
      total++; if ({s_axil_bvalid, s_axil_rvalid, reg_wr_en, reg_rd_en} !== 4'b0000) begin bad++; $display("FAIL rst_valid_en got=%b exp=0000", {s_axil_bvalid, s_axil_rvalid, reg_wr_en, reg_rd_en}); end
      total++; if ({s_axil_bresp, s_axil_rresp, s_axil_rdata, reg_wr_addr, reg_wr_data, reg_rd_addr} !== '0) begin bad++; $display("FAIL rst_data got=%h/%h/%h/%h/%h/%h exp=0", s_axil_bresp, s_axil_rresp, s_axil_rdata, reg_wr_addr, reg_wr_data, reg_rd_addr); end
      rstn = 1'b1;
      @(posedge clk); #1;
      total++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin bad++; $display("FAIL rst_release_readies got=%b exp=111", {s_axil_awready, s_axil_wready, s_axil_arready}); end
   endtask

   task automatic test_write_same_cycle();
      int p0;
      int n;
      p0 = wr_pulses;
      s_axil_awaddr = 32'h08; s_axil_wdata = 32'h0000_1000; s_axil_wstrb = 4'hF;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
      @(posedge clk); #1;  // E0: both handshakes
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      total++; if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 32'd2, 32'h1000}) begin bad++; $display("FAIL wr1_port got=%b/%0h/%0h exp=1/2/1000", reg_wr_en, reg_wr_addr, reg_wr_data); end
      total++; if ({s_axil_awready, s_axil_wready, s_axil_bvalid} !== 3'b000) begin bad++; $display("FAIL wr1_e0_flags got=%b exp=000", {s_axil_awready, s_axil_wready, s_axil_bvalid}); end
      @(posedge clk); #1;  // E1
      total++; if ({reg_wr_en, s_axil_bvalid} !== 2'b00) begin bad++; $display("FAIL wr1_e1 got=%b exp=00", {reg_wr_en, s_axil_bvalid}); end
      @(posedge clk); #1;  // E2
      total++; if ({s_axil_bvalid, s_axil_bresp} !== 3'b100) begin bad++; $display("FAIL wr1_bresp_e2 got=%b exp=100", {s_axil_bvalid, s_axil_bresp}); end
      s_axil_bready = 1'b1;
      n = 0;
      while (!s_axil_bvalid && n < 10) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;  // bready handshake
      s_axil_bready = 1'b0;
      total++; if ({s_axil_bvalid, s_axil_awready, s_axil_wready} !== 3'b011) begin bad++; $display("FAIL wr1_after_b got=%b exp=011", {s_axil_bvalid, s_axil_awready, s_axil_wready}); end
      total++; if (wr_pulses - p0 !== 1 || mem[2] !== 32'h1000) begin bad++; $display("FAIL wr1_pulses got=%0d/%0h exp=1/1000", wr_pulses - p0, mem[2]); end
   endtask

   task automatic test_write_w_first();
      int p0;
      int n;
      p0 = wr_pulses;
      s_axil_wdata = 32'hFF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      @(posedge clk); #1;  // W handshake
      s_axil_wvalid = 1'b0;
      total++; if ({s_axil_wready, s_axil_awready, reg_wr_en} !== 3'b010) begin bad++; $display("FAIL wf_after_w got=%b exp=010", {s_axil_wready, s_axil_awready, reg_wr_en}); end
      @(posedge clk); #1;
      total++; if ({s_axil_wready, reg_wr_en} !== 2'b00) begin bad++; $display("FAIL wf_wait got=%b exp=00", {s_axil_wready, reg_wr_en}); end
      @(posedge clk); #1;
      s_axil_awaddr = 32'h3C; s_axil_awvalid = 1'b1;
      @(posedge clk); #1;  // AW handshake, three edges after W
      s_axil_awvalid = 1'b0;
      total++; if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 32'd15, 32'hFF}) begin bad++; $display("FAIL wf_port got=%b/%0h/%0h exp=1/f/ff", reg_wr_en, reg_wr_addr, reg_wr_data); end
      s_axil_bready = 1'b1;
      n = 0;
      while (!s_axil_bvalid && n < 10) begin @(posedge clk); #1; n++; end
      total++; if ({s_axil_bvalid, s_axil_bresp} !== 3'b100) begin bad++; $display("FAIL wf_bresp got=%b exp=100", {s_axil_bvalid, s_axil_bresp}); end
      @(posedge clk); #1;
      s_axil_bready = 1'b0;
      total++; if (wr_pulses - p0 !== 1 || mem[15] !== 32'hFF) begin bad++; $display("FAIL wf_pulses got=%0d/%0h exp=1/ff", wr_pulses - p0, mem[15]); end
   endtask

   task automatic test_write_errors();
      int p0;
      logic [1:0] resp;
      logic [31:0] rd;
      bit to;
      p0 = wr_pulses;
      axi_write(32'h40, 32'h1234, 4'hF, resp, to);
      total++; if (to !== 1'b0 || resp !== 2'b10) begin bad++; $display("FAIL err_oor_bresp got=%b to=%0b exp=10", resp, to); end
      axi_write(32'h14, 32'h5555, 4'b0011, resp, to);
      total++; if (to !== 1'b0 || resp !== 2'b10) begin bad++; $display("FAIL err_strb_bresp got=%b to=%0b exp=10", resp, to); end
      total++; if (wr_pulses !== p0 || mem[5] !== 32'd5) begin bad++; $display("FAIL err_no_write got=%0d/%0h exp=%0d/5", wr_pulses, mem[5], p0); end
      axi_read(32'h44, rd, resp, to);
      total++; if (to !== 1'b0 || rd !== 32'd0 || resp !== 2'b10) begin bad++; $display("FAIL err_oor_read got=%0h/%b to=%0b exp=0/10", rd, resp, to); end
   endtask

   task automatic test_read_backpressure();
      s_axil_araddr = 32'h04; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
      @(posedge clk); #1;  // E0: AR handshake
      s_axil_arvalid = 1'b0;
      total++; if ({s_axil_arready, reg_rd_en, s_axil_rvalid} !== 3'b010 || reg_rd_addr !== 32'd1) begin bad++; $display("FAIL rd_e0 got=%b/%0h exp=010/1", {s_axil_arready, reg_rd_en, s_axil_rvalid}, reg_rd_addr); end
      @(posedge clk); #1;  // E1: capture
      total++; if ({s_axil_rvalid, reg_rd_en, s_axil_rresp} !== 4'b1000 || s_axil_rdata !== 32'd1) begin bad++; $display("FAIL rd_e1 got=%b/%0h exp=1000/1", {s_axil_rvalid, reg_rd_en, s_axil_rresp}, s_axil_rdata); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++; if ({s_axil_rvalid, s_axil_arready, s_axil_rresp} !== 4'b1000 || s_axil_rdata !== 32'd1) begin bad++; $display("FAIL rd_hold%0d got=%b/%0h exp=1000/1", i, {s_axil_rvalid, s_axil_arready, s_axil_rresp}, s_axil_rdata); end
      end
      s_axil_rready = 1'b1;
      @(posedge clk); #1;
      s_axil_rready = 1'b0;
      total++; if ({s_axil_rvalid, s_axil_arready} !== 2'b01) begin bad++; $display("FAIL rd_done got=%b exp=01", {s_axil_rvalid, s_axil_arready}); end
   endtask

   task automatic test_concurrent();
      int n;
      logic [1:0] resp;
      logic [31:0] rd;
      bit to;
      s_axil_awaddr = 32'h0C; s_axil_wdata = 32'hA; s_axil_wstrb = 4'hF;
      s_axil_araddr = 32'h0C;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
      @(posedge clk); #1;  // E0: AW, W and AR all accepted
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
      total++; if ({reg_wr_en, reg_rd_en} !== 2'b11 || reg_rd_addr !== 32'd3) begin bad++; $display("FAIL cc_e0 got=%b/%0h exp=11/3", {reg_wr_en, reg_rd_en}, reg_rd_addr); end
      @(posedge clk); #1;  // E1: read capture and register update on the same edge
      total++; if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'd3 || s_axil_rresp !== 2'b00) begin bad++; $display("FAIL cc_old_value got=%b/%0h/%b exp=1/3/00", s_axil_rvalid, s_axil_rdata, s_axil_rresp); end
      s_axil_rready = 1'b1; s_axil_bready = 1'b1;
      @(posedge clk); #1;
      s_axil_rready = 1'b0;
      n = 0;
      while (!s_axil_bvalid && n < 10) begin @(posedge clk); #1; n++; end
      total++; if ({s_axil_bvalid, s_axil_bresp} !== 3'b100) begin bad++; $display("FAIL cc_bresp got=%b exp=100", {s_axil_bvalid, s_axil_bresp}); end
      @(posedge clk); #1;
      s_axil_bready = 1'b0;
      axi_read(32'h0C, rd, resp, to);
      total++; if (to !== 1'b0 || rd !== 32'hA || resp !== 2'b00) begin bad++; $display("FAIL cc_new_value got=%0h/%b to=%0b exp=a/00", rd, resp, to); end
   endtask

   task automatic test_reset_mid();
      int p0;
      logic [1:0] resp;
      bit to;
      s_axil_awaddr = 32'h1C; s_axil_wdata = 32'h77; s_axil_wstrb = 4'hF;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
      @(posedge clk); #1;  // E0 write accepted
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      @(posedge clk); #1;  // E1
      s_axil_araddr = 32'h04; s_axil_arvalid = 1'b1;
      @(posedge clk); #1;  // E2: write in response, read in fetch
      s_axil_arvalid = 1'b0;
      total++; if ({s_axil_bvalid, reg_rd_en} !== 2'b11) begin bad++; $display("FAIL mr_pre got=%b exp=11", {s_axil_bvalid, reg_rd_en}); end
      #3 rstn = 1'b0;
      #1;
      total++; if ({s_axil_bvalid, s_axil_rvalid, reg_rd_en, reg_wr_en} !== 4'b0000) begin bad++; $display("FAIL mr_async got=%b exp=0000", {s_axil_bvalid, s_axil_rvalid, reg_rd_en, reg_wr_en}); end
      total++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin bad++; $display("FAIL mr_readies_low got=%b exp=000", {s_axil_awready, s_axil_wready, s_axil_arready}); end
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      total++; if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid} !== 5'b11100) begin bad++; $display("FAIL mr_release got=%b exp=11100", {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid}); end
      p0 = wr_pulses;
      axi_write(32'h18, 32'h66, 4'hF, resp, to);
      total++; if (to !== 1'b0 || resp !== 2'b00) begin bad++; $display("FAIL mr_fresh_bresp got=%b to=%0b exp=00", resp, to); end
      total++; if (wr_pulses - p0 !== 1 || mem[6] !== 32'h66) begin bad++; $display("FAIL mr_fresh_write got=%0d/%0h exp=1/66", wr_pulses - p0, mem[6]); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rstn = 1'b0;
      s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
      s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
      s_axil_bready = 1'b0;
      s_axil_araddr = '0; s_axil_arvalid = 1'b0;
      s_axil_rready = 1'b0;
      test_reset();
      test_write_same_cycle();
      test_write_w_first();
      test_write_errors();
      test_read_backpressure();
      test_concurrent();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
